// File: rtl/pkt_recv_fcp_gen_pkg.sv
// rtl/pkt_recv_fcp_gen_pkg.sv - shared FSM encoding, FCP field width and credit derivation
package pkt_recv_fcp_gen_pkg;

  localparam int FCP_FIELD_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_READ   = 2'd2,
    ST_UPDATE = 2'd3
  } fsm_state_t;

  function automatic logic [FCP_FIELD_WIDTH-1:0] initial_credit(input int buffer_addr_width);
    logic [FCP_FIELD_WIDTH-1:0] one;
    one = 1;
    return one << buffer_addr_width;
  endfunction

endpackage

// File: rtl/tdp_bram.sv
// rtl/tdp_bram.sv - true dual-port block RAM, single clock, registered read per port
module tdp_bram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Port B is evaluated last so it wins a same-address write collision.
  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) mem[a_addr] <= a_din;
      a_dout <= mem[a_addr];
    end
    if (b_en) begin
      if (b_we) mem[b_addr] <= b_din;
      b_dout <= mem[b_addr];
    end
  end

endmodule

// File: rtl/vc_drain_fifo.sv
// rtl/vc_drain_fifo.sv - FIFO of VC indices awaiting drain, exact full/empty via wrap bit
module vc_drain_fifo #(
  parameter int WIDTH      = 18,
  parameter int ADDR_WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0]  mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign head  = mem[rd_ptr[ADDR_WIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[ADDR_WIDTH-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pkt_recv_fcp_gen.sv
// rtl/pkt_recv_fcp_gen.sv - per-VC packet receive accounting with flow-control packet generation
module pkt_recv_fcp_gen
  import pkt_recv_fcp_gen_pkg::*;
#(
  parameter int QUEUE_INDEX_WIDTH = 18,
  parameter int DATA_WIDTH        = 64,
  parameter int BUFFER_ADDR_WIDTH = 14,
  parameter int FIFO_ADDR_WIDTH   = 10,
  parameter int DRAIN_INTERVAL    = 4,
  parameter int FCP_INTERVAL_LOG2 = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        s_axis_pkt_tdata,
  input  logic                         s_axis_pkt_tvalid,
  input  logic                         s_axis_pkt_tlast,
  input  logic [DATA_WIDTH/8-1:0]      s_axis_pkt_tkeep,
  output logic                         s_axis_pkt_tready,
  output logic                         fcp_valid,
  output logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc,
  output logic [FCP_FIELD_WIDTH-1:0]   fcp_fccl,
  output logic [FCP_FIELD_WIDTH-1:0]   fcp_qlen,
  output logic [FCP_FIELD_WIDTH-1:0]   fcp_fccr,
  output logic [63:0]                  rx_pkt_count,
  output logic [31:0]                  drop_count,
  output logic                         init_done
);

  localparam int QW    = QUEUE_INDEX_WIDTH;
  localparam int FW    = FCP_FIELD_WIDTH;
  localparam int TMR_W = (DRAIN_INTERVAL > 1) ? $clog2(DRAIN_INTERVAL) : 1;
  localparam logic [FW-1:0]    INITIAL_CREDIT = initial_credit(BUFFER_ADDR_WIDTH);
  localparam logic [FW-1:0]    FCP_MASK       = (FW'(1) << FCP_INTERVAL_LOG2) - FW'(1);
  localparam logic [TMR_W-1:0] TMR_LAST       = TMR_W'(DRAIN_INTERVAL - 1);

  fsm_state_t       state;
  logic [QW-1:0]    init_ptr;
  logic [QW-1:0]    cur_vc;
  logic [QW-1:0]    pkt_vc;
  logic [QW-1:0]    ev_vc;
  logic [QW-1:0]    fifo_head;
  logic             cur_is_drain;
  logic             in_pkt;
  logic             drain_pending;
  logic [TMR_W-1:0] drain_tmr;
  logic [FW-1:0]    g_drain;
  logic [FW-1:0]    rx_q;
  logic [FW-1:0]    drain_q;
  logic [FW-1:0]    rx_new;
  logic [FW-1:0]    drain_new;
  logic [FW-1:0]    g_drain_new;
  logic [FW-1:0]    qlen_new;
  logic             fcp_emit;
  logic             beat;
  logic             ev;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             ram_init;
  logic             ram_rd;
  logic             rx_we;
  logic             drain_we;
  logic [QW-1:0]    ram_waddr;
  logic [FW-1:0]    rx_b_unused;
  logic [FW-1:0]    drain_b_unused;
  logic             unused_in;

  assign unused_in = ^{s_axis_pkt_tkeep, s_axis_pkt_tdata};

  assign s_axis_pkt_tready = (state == ST_IDLE) && !drain_pending && !rst;
  assign beat      = s_axis_pkt_tvalid && s_axis_pkt_tready;
  assign ev        = beat && s_axis_pkt_tlast;
  assign ev_vc     = in_pkt ? pkt_vc : s_axis_pkt_tdata[QW+15:16];
  assign fifo_pop  = (state == ST_IDLE) && drain_pending;
  assign fifo_push = ev && !fifo_full;

  always_comb begin
    rx_new      = cur_is_drain ? rx_q : rx_q + FW'(1);
    drain_new   = cur_is_drain ? drain_q + FW'(1) : drain_q;
    g_drain_new = cur_is_drain ? g_drain + FW'(1) : g_drain;
    qlen_new    = rx_new - drain_new;
    fcp_emit    = cur_is_drain ? (qlen_new == '0) : ((rx_new & FCP_MASK) == '0);
  end

  // Writes are gated by rst so an interrupted update never lands; only the INIT sweep writes after reset.
  assign ram_init  = (state == ST_INIT) && !rst;
  assign ram_rd    = (state == ST_READ) && !rst;
  assign rx_we     = ram_init || ((state == ST_UPDATE) && !cur_is_drain && !rst);
  assign drain_we  = ram_init || ((state == ST_UPDATE) && cur_is_drain && !rst);
  assign ram_waddr = ram_init ? init_ptr : cur_vc;

  tdp_bram #(.DATA_WIDTH(FW), .ADDR_WIDTH(QW)) u_rx_ram (
    .clk    (clk),
    .a_en   (ram_rd),
    .a_we   (1'b0),
    .a_addr (cur_vc),
    .a_din  ('0),
    .a_dout (rx_q),
    .b_en   (rx_we),
    .b_we   (rx_we),
    .b_addr (ram_waddr),
    .b_din  (ram_init ? '0 : rx_new),
    .b_dout (rx_b_unused)
  );

  tdp_bram #(.DATA_WIDTH(FW), .ADDR_WIDTH(QW)) u_drain_ram (
    .clk    (clk),
    .a_en   (ram_rd),
    .a_we   (1'b0),
    .a_addr (cur_vc),
    .a_din  ('0),
    .a_dout (drain_q),
    .b_en   (drain_we),
    .b_we   (drain_we),
    .b_addr (ram_waddr),
    .b_din  (ram_init ? '0 : drain_new),
    .b_dout (drain_b_unused)
  );

  vc_drain_fifo #(.WIDTH(QW), .ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_drain_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (ev_vc),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_INIT;
      init_ptr      <= '0;
      cur_vc        <= '0;
      pkt_vc        <= '0;
      cur_is_drain  <= 1'b0;
      in_pkt        <= 1'b0;
      drain_pending <= 1'b0;
      drain_tmr     <= '0;
      g_drain       <= '0;
      fcp_valid     <= 1'b0;
      fcp_vc        <= '0;
      fcp_fccl      <= '0;
      fcp_qlen      <= '0;
      fcp_fccr      <= '0;
      rx_pkt_count  <= '0;
      drop_count    <= '0;
      init_done     <= 1'b0;
    end else begin
      fcp_valid <= 1'b0;
      // A pop already consumes the pending opportunity, so don't re-arm on the same cycle.
      if (state != ST_INIT) begin
        if (drain_tmr == TMR_LAST) begin
          drain_tmr <= '0;
          if (!fifo_empty && !fifo_pop) drain_pending <= 1'b1;
        end else begin
          drain_tmr <= drain_tmr + 1'b1;
        end
      end
      if (beat) begin
        in_pkt <= !s_axis_pkt_tlast;
        if (!in_pkt) pkt_vc <= s_axis_pkt_tdata[QW+15:16];
      end
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == {QW{1'b1}}) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (drain_pending) begin
            drain_pending <= 1'b0;
            cur_vc        <= fifo_head;
            cur_is_drain  <= 1'b1;
            state         <= ST_READ;
          end else if (ev) begin
            if (fifo_full) begin
              drop_count <= drop_count + 1'b1;
            end else begin
              cur_vc       <= ev_vc;
              cur_is_drain <= 1'b0;
              rx_pkt_count <= rx_pkt_count + 1'b1;
              state        <= ST_READ;
            end
          end
        end
        ST_READ: state <= ST_UPDATE;
        ST_UPDATE: begin
          state   <= ST_IDLE;
          g_drain <= g_drain_new;
          if (fcp_emit) begin
            fcp_valid <= 1'b1;
            fcp_vc    <= cur_vc;
            fcp_fccl  <= INITIAL_CREDIT + g_drain_new;
            fcp_qlen  <= qlen_new;
            fcp_fccr  <= drain_new;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_recv_fcp_gen.sv
// tb/tb_pkt_recv_fcp_gen.sv - directed self-checking bench for pkt_recv_fcp_gen
module tb_pkt_recv_fcp_gen;

  localparam int QW  = 4;
  localparam int DW  = 64;
  localparam int BAW = 14;
  localparam int FAW = 2;
  localparam int DI  = 128;
  localparam int FIL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic [DW/8-1:0] tkeep = '1;
  logic          tready;
  logic          fcp_valid;
  logic [QW-1:0] fcp_vc;
  logic [31:0]   fcp_fccl;
  logic [31:0]   fcp_qlen;
  logic [31:0]   fcp_fccr;
  logic [63:0]   rx_pkt_count;
  logic [31:0]   drop_count;
  logic          init_done;

  int n_cmp = 0;
  int n_bad = 0;
  int fcp_seen = 0;
  logic [QW-1:0] last_vc;
  logic [31:0]   last_fccl;
  logic [31:0]   last_qlen;
  logic [31:0]   last_fccr;

  always #5 clk = ~clk;

  pkt_recv_fcp_gen #(
    .QUEUE_INDEX_WIDTH (QW),
    .DATA_WIDTH        (DW),
    .BUFFER_ADDR_WIDTH (BAW),
    .FIFO_ADDR_WIDTH   (FAW),
    .DRAIN_INTERVAL    (DI),
    .FCP_INTERVAL_LOG2 (FIL)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_pkt_tdata  (tdata),
    .s_axis_pkt_tvalid (tvalid),
    .s_axis_pkt_tlast  (tlast),
    .s_axis_pkt_tkeep  (tkeep),
    .s_axis_pkt_tready (tready),
    .fcp_valid         (fcp_valid),
    .fcp_vc            (fcp_vc),
    .fcp_fccl          (fcp_fccl),
    .fcp_qlen          (fcp_qlen),
    .fcp_fccr          (fcp_fccr),
    .rx_pkt_count      (rx_pkt_count),
    .drop_count        (drop_count),
    .init_done         (init_done)
  );

  always @(negedge clk) begin
    if (fcp_valid === 1'b1) begin
      fcp_seen++;
      last_vc   = fcp_vc;
      last_fccl = fcp_fccl;
      last_qlen = fcp_qlen;
      last_fccr = fcp_fccr;
    end
  end

  // Called on a falling edge; returns on the falling edge after the beat is taken.
  task automatic drive_beat(input logic [QW-1:0] vc, input logic last);
    int waited;
    tdata  = (64'(vc) << 16) | 64'hDEAD_0000_0000_BEEF;
    tvalid = 1'b1;
    tlast  = last;
    waited = 0;
    while (tready !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (tready !== 1'b1) begin
      n_bad++;
      $display("FAIL handshake_timeout vc=%0d tready=%b required=1", vc, tready);
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int bad_fcp;
    bad_fcp = 0;
    for (int k = 1; k <= (1 << QW) + 1; k++) begin
      @(negedge clk);
      if (fcp_valid !== 1'b0) bad_fcp++;
      if (k == (1 << QW) - 1) begin
        n_cmp++;
        if (init_done !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_init_early init_done=%b required=0", tag, init_done);
        end
      end
    end
    n_cmp++;
    if (bad_fcp != 0) begin n_bad++; $display("FAIL %s_fcp_in_init pulses=%0d required=0", tag, bad_fcp); end
    n_cmp++;
    if (init_done !== 1'b1) begin n_bad++; $display("FAIL %s_init_done got=%b required=1", tag, init_done); end
    n_cmp++;
    if (tready !== 1'b1) begin n_bad++; $display("FAIL %s_tready_idle got=%b required=1", tag, tready); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tready !== 1'b0) begin n_bad++; $display("FAIL rst_tready got=%b required=0", tready); end
    n_cmp++;
    if (fcp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_fcp_valid got=%b required=0", fcp_valid); end
    n_cmp++;
    if ({fcp_vc, fcp_fccl, fcp_qlen, fcp_fccr} !== '0) begin
      n_bad++;
      $display("FAIL rst_fcp_fields vc=%0d fccl=%0d qlen=%0d fccr=%0d required=all 0", fcp_vc, fcp_fccl, fcp_qlen, fcp_fccr);
    end
    n_cmp++;
    if (rx_pkt_count !== 64'd0 || drop_count !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_counters rx=%0d drop=%0d required=0/0", rx_pkt_count, drop_count);
    end
    n_cmp++;
    if (init_done !== 1'b0) begin n_bad++; $display("FAIL rst_init_done got=%b required=0", init_done); end
    rst = 1'b0;
    wait_init("reset");
  endtask

  task automatic test_credit_report();
    int fcp0;
    fcp0 = fcp_seen;
    for (int i = 0; i < 4; i++) drive_beat(4'd5, 1'b1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (fcp_seen - fcp0 != 1) begin n_bad++; $display("FAIL arr_fcp_count got=%0d required=1", fcp_seen - fcp0); end
    n_cmp++;
    if (last_vc !== 4'd5) begin n_bad++; $display("FAIL arr_fcp_vc got=%0d required=5", last_vc); end
    n_cmp++;
    if (last_qlen !== 32'd4) begin n_bad++; $display("FAIL arr_fcp_qlen got=%0d required=4", last_qlen); end
    n_cmp++;
    if (last_fccr !== 32'd0) begin n_bad++; $display("FAIL arr_fcp_fccr got=%0d required=0", last_fccr); end
    n_cmp++;
    if (last_fccl !== 32'd16384) begin n_bad++; $display("FAIL arr_fcp_fccl got=%0d required=16384", last_fccl); end
    n_cmp++;
    if (rx_pkt_count !== 64'd4) begin n_bad++; $display("FAIL arr_rx_count got=%0d required=4", rx_pkt_count); end
  endtask

  task automatic test_fifo_full_drop();
    drive_beat(4'd6, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (drop_count !== 32'd1) begin n_bad++; $display("FAIL drop_count got=%0d required=1", drop_count); end
    n_cmp++;
    if (rx_pkt_count !== 64'd4) begin n_bad++; $display("FAIL drop_rx_count got=%0d required=4", rx_pkt_count); end
  endtask

  task automatic test_drain();
    int fcp0;
    int waited;
    logic [QW-1:0] vc;
    logic [31:0] fccl, qlen, fccr;
    fcp0 = fcp_seen;
    waited = 0;
    while (fcp_valid !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (fcp_valid !== 1'b1) begin n_bad++; $display("FAIL drain_fcp_timeout fcp_valid=%b required=1", fcp_valid); end
    vc = fcp_vc; fccl = fcp_fccl; qlen = fcp_qlen; fccr = fcp_fccr;
    @(negedge clk);
    n_cmp++;
    if (vc !== 4'd5) begin n_bad++; $display("FAIL drain_fcp_vc got=%0d required=5", vc); end
    n_cmp++;
    if (qlen !== 32'd0) begin n_bad++; $display("FAIL drain_fcp_qlen got=%0d required=0", qlen); end
    n_cmp++;
    if (fccr !== 32'd4) begin n_bad++; $display("FAIL drain_fcp_fccr got=%0d required=4", fccr); end
    n_cmp++;
    if (fccl !== 32'd16388) begin n_bad++; $display("FAIL drain_fcp_fccl got=%0d required=16388", fccl); end
    n_cmp++;
    if (fcp_seen - fcp0 != 1) begin n_bad++; $display("FAIL drain_fcp_count got=%0d required=1", fcp_seen - fcp0); end
  endtask

  task automatic test_drain_priority();
    int waited;
    int stall;
    // Two-beat packet: the VC field of the last beat must be ignored.
    drive_beat(4'd9, 1'b0);
    drive_beat(4'd12, 1'b1);
    repeat (2) @(negedge clk);
    waited = 0;
    while (tready === 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (tready !== 1'b0) begin n_bad++; $display("FAIL prio_pending_timeout tready=%b required=0", tready); end
    tdata  = (64'(4'd10) << 16) | 64'hDEAD_0000_0000_BEEF;
    tvalid = 1'b1;
    tlast  = 1'b1;
    stall  = 0;
    @(negedge clk);
    while (tready !== 1'b1 && stall < 20) begin
      stall++;
      @(negedge clk);
    end
    n_cmp++;
    if (stall != 2) begin n_bad++; $display("FAIL prio_stall_cycles got=%0d required=2", stall); end
    n_cmp++;
    if (rx_pkt_count !== 64'd5) begin n_bad++; $display("FAIL prio_held_rx_count got=%0d required=5", rx_pkt_count); end
    n_cmp++;
    if (fcp_valid !== 1'b1 || fcp_vc !== 4'd9) begin
      n_bad++;
      $display("FAIL prio_drain_fcp valid=%b vc=%0d required=1/9", fcp_valid, fcp_vc);
    end
    n_cmp++;
    if (fcp_qlen !== 32'd0 || fcp_fccr !== 32'd1 || fcp_fccl !== 32'd16389) begin
      n_bad++;
      $display("FAIL prio_drain_fields qlen=%0d fccr=%0d fccl=%0d required=0/1/16389", fcp_qlen, fcp_fccr, fcp_fccl);
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    n_cmp++;
    if (rx_pkt_count !== 64'd6) begin n_bad++; $display("FAIL prio_accept_rx_count got=%0d required=6", rx_pkt_count); end
  endtask

  task automatic test_reset_in_read();
    int fcp0;
    drive_beat(4'd3, 1'b1);
    drive_beat(4'd3, 1'b1);
    drive_beat(4'd3, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tready !== 1'b0 || fcp_valid !== 1'b0 || init_done !== 1'b0) begin
      n_bad++;
      $display("FAIL rrd_flags tready=%b fcp_valid=%b init_done=%b required=0/0/0", tready, fcp_valid, init_done);
    end
    n_cmp++;
    if (rx_pkt_count !== 64'd0 || drop_count !== 32'd0 || fcp_fccl !== 32'd0 || fcp_vc !== 4'd0) begin
      n_bad++;
      $display("FAIL rrd_values rx=%0d drop=%0d fccl=%0d vc=%0d required=all 0", rx_pkt_count, drop_count, fcp_fccl, fcp_vc);
    end
    rst = 1'b0;
    wait_init("rrd");
    fcp0 = fcp_seen;
    for (int i = 0; i < 4; i++) drive_beat(4'd3, 1'b1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (fcp_seen - fcp0 != 1) begin n_bad++; $display("FAIL rrd_fcp_count got=%0d required=1", fcp_seen - fcp0); end
    n_cmp++;
    if (last_vc !== 4'd3 || last_qlen !== 32'd4) begin
      n_bad++;
      $display("FAIL rrd_fcp_vc_qlen vc=%0d qlen=%0d required=3/4", last_vc, last_qlen);
    end
    n_cmp++;
    if (last_fccr !== 32'd0 || last_fccl !== 32'd16384) begin
      n_bad++;
      $display("FAIL rrd_fcp_credit fccr=%0d fccl=%0d required=0/16384", last_fccr, last_fccl);
    end
    n_cmp++;
    if (rx_pkt_count !== 64'd4) begin n_bad++; $display("FAIL rrd_rx_count got=%0d required=4", rx_pkt_count); end
  endtask

  initial begin
    test_reset();
    test_credit_report();
    test_fifo_full_drop();
    test_drain();
    test_drain_priority();
    test_reset_in_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pkt_recv_fcp_gen.md
PKT_RECV_FCP_GEN -- requirements
Module: pkt_recv_fcp_gen

Interface
REQ-001 Parameters: QUEUE_INDEX_WIDTH, default 18, VC index width; DATA_WIDTH, default 64, packet bus width; BUFFER_ADDR_WIDTH, default 14, shared-buffer credit exponent (INITIAL_CREDIT = 2**BUFFER_ADDR_WIDTH); FIFO_ADDR_WIDTH, default 10, drain FIFO depth exponent; DRAIN_INTERVAL, default 4, cycles per drain opportunity; FCP_INTERVAL_LOG2, default 2, arrivals per VC between FCPs.
REQ-002 Ports: clk in 1 clock; rst in 1 reset; one clock, reset synchronous and active-high.
REQ-003 s_axis_pkt_tdata in DATA_WIDTH, VC in bits [QUEUE_INDEX_WIDTH+15:16] of first beat; s_axis_pkt_tvalid in 1; s_axis_pkt_tlast in 1; s_axis_pkt_tkeep in DATA_WIDTH/8, ignored; s_axis_pkt_tready out 1.
REQ-004 fcp_valid out 1; fcp_vc out QUEUE_INDEX_WIDTH; fcp_fccl out 32, global credit limit; fcp_qlen out 32, VC queue length; fcp_fccr out 32, VC drained count.
REQ-005 rx_pkt_count out 64, accepted packets; drop_count out 32, packets dropped on FIFO full; init_done out 1.

Function
REQ-006 Per-VC state: rx_cnt (32b) and drain_cnt (32b) in two RAMs; qlen = rx_cnt - drain_cnt, modulo 2^32.
REQ-007 Global drained counter g_drain (32b); fccl = INITIAL_CREDIT + g_drain, modulo 2^32.
REQ-008 FSM states INIT, IDLE, READ, UPDATE; INIT writes zero to both RAMs at address 0..2^QUEUE_INDEX_WIDTH-1, one per cycle, then IDLE with init_done=1.
REQ-009 Drain timer counts 0..DRAIN_INTERVAL-1 continuously after INIT; at terminal count with drain FIFO non-empty, sets sticky drain_pending.
REQ-010 tready = 1 only in IDLE with drain_pending=0; every beat accepted while tready=1; VC latched on first beat of packet; event fires on tlast beat.
REQ-011 IDLE priority: drain_pending over arrival; drain pops FIFO head VC, clears drain_pending, goes READ.
REQ-012 Arrival event: FIFO full -> drop_count+1, no RAM update, stay IDLE; else push VC into FIFO, rx_pkt_count+1, go READ.
REQ-013 READ: one cycle RAM latency for VC's rx_cnt and drain_cnt; then UPDATE.
REQ-014 UPDATE arrival: rx_cnt+1 written; FCP emitted if new rx_cnt[FCP_INTERVAL_LOG2-1:0]==0.
REQ-015 UPDATE drain: drain_cnt+1 written, g_drain+1; FCP emitted if new qlen==0.
REQ-016 FCP fields use post-update values; fcp_valid single-cycle pulse, cycle after UPDATE (3 cycles after handshake/pop); UPDATE -> IDLE always.
REQ-017 Same-cycle FIFO push and pop impossible by construction (serialized FSM); full/empty flags exact at 2^FIFO_ADDR_WIDTH entries.
REQ-018 All counters wrap silently at 2^width.

Reset
REQ-019 rst: FSM -> INIT, init pointer 0, FIFO emptied, drain timer 0, drain_pending 0, g_drain 0.
REQ-020 Reset values: tready 0, fcp_valid 0, fcp_vc/fccl/qlen/fccr 0, rx_pkt_count 0, drop_count 0, init_done 0.
REQ-021 rst mid-packet or mid-update discards in-flight event; RAM writes after rst only from INIT sweep.

Structure
REQ-022 Shared package: FSM state encodings, INITIAL_CREDIT derivation, FCP field width (32).
REQ-023 RAMs instantiate existing tdp_bram (DATA_WIDTH 32, ADDR_WIDTH QUEUE_INDEX_WIDTH); drain FIFO is one sub-module, vc_drain_fifo.

Verification
REQ-024 Reset, 2^QUEUE_INDEX_WIDTH+1 cycles -> init_done=1, tready=1, no fcp_valid during INIT.
REQ-025 4 packets on VC 5, drain stalled (DRAIN_INTERVAL huge) -> one FCP after 4th: vc=5, qlen=4, fccr=0, fccl=16384.
REQ-026 After 025, enable drain -> 4 drains, FCP at qlen=0: vc=5, fccr=4, fccl=16388.
REQ-027 Fill FIFO (FIFO_ADDR_WIDTH=2, 4 packets, no drain), send 5th -> drop_count=1, rx_pkt_count=4.
REQ-028 drain_pending set while packet presented -> tready 0 until drain UPDATE done; packet then accepted.
REQ-029 Assert rst in READ -> outputs at reset values next cycle, INIT sweep restarts, rx_cnt of VC read back 0.
